bundle_sum_accum: RTL and testbench

BUNDLE_SUM_ACCUM -- requirements
Module: bundle_sum_accum

---
 rtl/bundle_sum_accum.sv | 93 +++++++++
 tb/tb_bundle_sum_accum.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bundle_sum_accum.sv
// Frame accumulator for 4-bit adder sums: running sum, max and count,
// held for a valid/ready handshake once the frame closes.
module bundle_sum_accum #(
  parameter int FRAME_LEN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] io_in_bits,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  input  logic       io_flush,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic [7:0] io_out_sum,
  output logic [3:0] io_out_max,
  output logic [4:0] io_out_count
);

  localparam logic [4:0] FL = 5'(FRAME_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sum_q, sum_d;
  logic [3:0] max_q, max_d;
  logic [4:0] cnt_q, cnt_d;

  logic       acc;
  logic [7:0] sum_acc;
  logic [3:0] max_acc;
  logic [4:0] cnt_acc;
  logic       close;

  assign acc     = (state_q == ACCUM) && io_in_valid;
  assign sum_acc = sum_q + {4'b0000, io_in_bits};
  assign max_acc = (io_in_bits > max_q) ? io_in_bits : max_q;
  assign cnt_acc = cnt_q + 5'd1;

  // A flush closes the frame only if it holds at least one sample,
  // counting a sample accepted on the same edge.
  assign close = (acc && (cnt_acc == FL)) ||
                 (io_flush && ((cnt_q != 5'd0) || acc));

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        if (acc) begin
          sum_d = sum_acc;
          max_d = max_acc;
          cnt_d = cnt_acc;
        end
        if (close) state_d = HOLD;
      end
      HOLD: begin
        if (io_out_ready) begin
          state_d = ACCUM;
          sum_d   = 8'd0;
          max_d   = 4'd0;
          cnt_d   = 5'd0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ACCUM;
      sum_q   <= 8'd0;
      max_q   <= 4'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io_in_ready  = (state_q == ACCUM);
  assign io_out_valid = (state_q == HOLD);
  assign io_out_sum   = sum_q;
  assign io_out_max   = max_q;
  assign io_out_count = cnt_q;

endmodule

// File: tb/tb_bundle_sum_accum.sv
// Bench for bundle_sum_accum: FRAME_LEN 4 and 16 instances on shared
// stimulus, checked each cycle against a sample-list frame model.
module tb_bundle_sum_accum;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in_bits;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  logic       a_rdy, a_vld, b_rdy, b_vld;
  logic [7:0] a_sum, b_sum;
  logic [3:0] a_max, b_max;
  logic [4:0] a_cnt, b_cnt;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  bit hold [2];
  int n    [2];
  int smp  [2][16];

  always #5 clock = ~clock;

  bundle_sum_accum #(.FRAME_LEN(4)) u_a (
    .clock(clock), .reset(reset),
    .io_in_bits(in_bits), .io_in_valid(in_valid),
    .io_in_ready(a_rdy), .io_flush(flush),
    .io_out_valid(a_vld), .io_out_ready(out_ready),
    .io_out_sum(a_sum), .io_out_max(a_max),
    .io_out_count(a_cnt)
  );

  bundle_sum_accum #(.FRAME_LEN(16)) u_b (
    .clock(clock), .reset(reset),
    .io_in_bits(in_bits), .io_in_valid(in_valid),
    .io_in_ready(b_rdy), .io_flush(flush),
    .io_out_valid(b_vld), .io_out_ready(out_ready),
    .io_out_sum(b_sum), .io_out_max(b_max),
    .io_out_count(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_sum(input int k);
    int s = 0;
    for (int i = 0; i < n[k]; i++) s += smp[k][i];
    return s;
  endfunction

  function automatic int m_max(input int k);
    int m = 0;
    for (int i = 0; i < n[k]; i++) if (smp[k][i] > m) m = smp[k][i];
    return m;
  endfunction

  // Frame rules applied to one rising edge.
  task automatic m_edge(input int k, input int b, input bit v,
                        input bit f, input bit r, input bit rs);
    int len = (k == 0) ? 4 : 16;
    if (!rs) begin
      hold[k] = 1'b0;
      n[k]    = 0;
    end else if (hold[k]) begin
      if (r) begin
        hold[k] = 1'b0;
        n[k]    = 0;
      end
    end else begin
      if (v) begin
        smp[k][n[k]] = b;
        n[k]++;
      end
      if ((v && n[k] == len) || (f && n[k] > 0)) hold[k] = 1'b1;
    end
  endtask

  task automatic check_inst(input int k, input logic rdy,
                            input logic vld, input logic [7:0] s,
                            input logic [3:0] m, input logic [4:0] c);
    string p = (k == 0) ? "L4" : "L16";
    chk({p, "_in_ready"}, 32'(rdy), 32'(!hold[k]));
    chk({p, "_out_valid"}, 32'(vld), 32'(hold[k]));
    chk({p, "_sum"}, 32'(s), 32'(m_sum(k)));
    chk({p, "_max"}, 32'(m), 32'(m_max(k)));
    chk({p, "_count"}, 32'(c), 32'(n[k]));
  endtask

  task automatic step(input logic [3:0] b, input bit v, input bit f,
                      input bit r, input bit rs);
    in_bits   = b;
    in_valid  = v;
    flush     = f;
    out_ready = r;
    reset     = rs;
    @(negedge clock);
    if (chk_en) begin
      check_inst(0, a_rdy, a_vld, a_sum, a_max, a_cnt);
      check_inst(1, b_rdy, b_vld, b_sum, b_max, b_cnt);
    end
    @(posedge clock);
    m_edge(0, int'(b), v, f, r, rs);
    m_edge(1, int'(b), v, f, r, rs);
    #1;
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(4'd0, 1'b0, 1'b0, r, 1'b1);
  endtask

  initial begin
    hold[0] = 1'b0; hold[1] = 1'b0;
    n[0] = 0; n[1] = 0;

    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ready", 32'(a_rdy), 32'd1);
    chk("reset_count", 32'(a_cnt), 32'd0);

    // Back-to-back frame of four with downstream always ready.
    step(4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("f4_valid", 32'(a_vld), 32'd1);
    chk("f4_sum", 32'(a_sum), 32'd26);
    chk("f4_max", 32'(a_max), 32'd15);
    chk("f4_count", 32'(a_cnt), 32'd4);
    step(4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("f4_ready_back", 32'(a_rdy), 32'd1);
    chk("f4_cleared", 32'(a_sum), 32'd0);
    idle(2, 1'b1);

    // Sixteen samples of 15 into a fresh frame.
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("f16_valid", 32'(b_vld), 32'd1);
    chk("f16_sum", 32'(b_sum), 32'd240);
    chk("f16_count", 32'(b_cnt), 32'd16);
    idle(2, 1'b1);

    // Flush together with a sample, then flush on an empty frame.
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_sum", 32'(a_sum), 32'd16);
    chk("flush_max", 32'(a_max), 32'd9);
    chk("flush_count", 32'(a_cnt), 32'd3);
    step(4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("empty_flush", 32'(a_vld), 32'd0);
    idle(1, 1'b1);

    // Downstream stalls five cycles with input pressure.
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'(i + 4), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stall_sum", 32'(a_sum), 32'd22);
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);

    // Reset while holding a frame, then mid-frame.
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_hold_valid", 32'(a_vld), 32'd0);
    step(4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_count", 32'(a_cnt), 32'd0);
    step(4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("after_rst_sum", 32'(a_sum), 32'd4);
    idle(1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 49) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
